// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset CPU: sequences instruction phases,
// decodes the IR into one-hot ALU function, operand selects and write enables.
module multi_cycle_ctrl #(
   parameter int unsigned INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [31:0]          instr,
   input  logic                 mem_ready,
   input  logic                 alu_zero,
   output logic [11:0]          alu_f,
   output logic [1:0]           alu_src_a,
   output logic [2:0]           alu_src_b,
   output logic [1:0]           pc_src,
   output logic                 pc_we,
   output logic                 ir_we,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 iord,
   output logic                 rf_we,
   output logic                 reg_dst,
   output logic                 mem_to_reg,
   output logic                 illegal,
   output logic [3:0]           state,
   output logic [INSTRET_W-1:0] instret
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC     = 4'd6,
      S_ALU_WB   = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9
   } state_e;

   localparam logic [11:0] F_ADD  = 12'h001, F_SUB = 12'h002, F_SLT = 12'h004,
                           F_SLTU = 12'h008, F_AND = 12'h010, F_OR  = 12'h020,
                           F_NOR  = 12'h040, F_XOR = 12'h080, F_SLL = 12'h100,
                           F_SRL  = 12'h200, F_SRA = 12'h400, F_PASSB = 12'h800;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_BEQ  = 6'h04,
                          OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09,
                          OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                          OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI  = 6'h0F,
                          OP_LW    = 6'h23, OP_SW    = 6'h2B;

   localparam logic [1:0] SA_PC = 2'd0, SA_RS = 2'd1, SA_RT = 2'd2;
   localparam logic [2:0] SB_RT = 3'd0, SB_FOUR = 3'd1, SB_SEXT = 3'd2, SB_ZEXT = 3'd3,
                          SB_BRANCH = 3'd4, SB_SHAMT = 3'd5, SB_LUI = 3'd6, SB_RS = 3'd7;
   localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2;

   state_e                 state_q, state_d;
   logic [INSTRET_W-1:0]   instret_q;
   logic                   retire;

   logic [5:0]  opcode, funct;
   logic        r_legal, i_legal;
   logic [11:0] r_f, i_f;
   logic [1:0]  r_a;
   logic [2:0]  r_b, i_b;
   logic        unused_instr;

   assign opcode       = instr[31:26];
   assign funct        = instr[5:0];
   assign unused_instr = ^instr[25:6];

   // R-type funct decode; shifts take the shifted value from rt on port a.
   always_comb begin
      r_legal = 1'b1;
      r_f     = F_ADD;
      r_a     = SA_RS;
      r_b     = SB_RT;
      case (funct)
         6'h20, 6'h21: r_f = F_ADD;
         6'h22, 6'h23: r_f = F_SUB;
         6'h24:        r_f = F_AND;
         6'h25:        r_f = F_OR;
         6'h26:        r_f = F_XOR;
         6'h27:        r_f = F_NOR;
         6'h2A:        r_f = F_SLT;
         6'h2B:        r_f = F_SLTU;
         6'h00:        begin r_f = F_SLL; r_a = SA_RT; r_b = SB_SHAMT; end
         6'h02:        begin r_f = F_SRL; r_a = SA_RT; r_b = SB_SHAMT; end
         6'h03:        begin r_f = F_SRA; r_a = SA_RT; r_b = SB_SHAMT; end
         6'h04:        begin r_f = F_SLL; r_a = SA_RT; r_b = SB_RS; end
         6'h06:        begin r_f = F_SRL; r_a = SA_RT; r_b = SB_RS; end
         6'h07:        begin r_f = F_SRA; r_a = SA_RT; r_b = SB_RS; end
         default:      r_legal = 1'b0;
      endcase
   end

   always_comb begin
      i_legal = 1'b1;
      i_f     = F_ADD;
      i_b     = SB_SEXT;
      case (opcode)
         OP_ADDI, OP_ADDIU: i_f = F_ADD;
         OP_SLTI:           i_f = F_SLT;
         OP_SLTIU:          i_f = F_SLTU;
         OP_ANDI:           begin i_f = F_AND;   i_b = SB_ZEXT; end
         OP_ORI:            begin i_f = F_OR;    i_b = SB_ZEXT; end
         OP_XORI:           begin i_f = F_XOR;   i_b = SB_ZEXT; end
         OP_LUI:            begin i_f = F_PASSB; i_b = SB_LUI;  end
         default:           i_legal = 1'b0;
      endcase
   end

   // NOTE: every output gets a default before the case so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      alu_f      = F_ADD;
      alu_src_a  = SA_PC;
      alu_src_b  = SB_RT;
      pc_src     = PC_ALU;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      rf_we      = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SB_FOUR;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = SB_BRANCH;
            if (opcode == OP_LW || opcode == OP_SW)        state_d = S_MEM_ADDR;
            else if (opcode == OP_RTYPE && r_legal)        state_d = S_EXEC;
            else if (i_legal)                              state_d = S_EXEC;
            else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = S_BRANCH;
            else if (opcode == OP_J)                       state_d = S_JUMP;
            else begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEM_ADDR: begin
            alu_src_a = SA_RS;
            alu_src_b = SB_SEXT;
            state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            rf_we      = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            if (opcode == OP_RTYPE) begin
               alu_f     = r_f;
               alu_src_a = r_a;
               alu_src_b = r_b;
            end else begin
               alu_f     = i_f;
               alu_src_a = SA_RS;
               alu_src_b = i_b;
            end
            state_d = S_ALU_WB;
         end
         S_ALU_WB: begin
            rf_we   = 1'b1;
            reg_dst = (opcode == OP_RTYPE);
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            alu_f     = F_SUB;
            alu_src_a = SA_RS;
            alu_src_b = SB_RT;
            pc_src    = PC_ALUOUT;
            pc_we     = (opcode == OP_BNE) ? !alu_zero : alu_zero;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_src  = PC_JUMP;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // Outputs are combinational, so gate them directly while reset is held.
      if (!rstn) begin
         state_d    = S_FETCH;
         retire     = 1'b0;
         alu_f      = F_ADD;
         alu_src_a  = SA_PC;
         alu_src_b  = SB_RT;
         pc_src     = PC_ALU;
         pc_we      = 1'b0;
         ir_we      = 1'b0;
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         iord       = 1'b0;
         rf_we      = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         illegal    = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) instret_q <= instret_q + INSTRET_W'(1);
      end
   end

   assign state   = state_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: a cycle-by-cycle vector table of
// instruction traces plus hand sequences for reset, counter wrap and mid-op reset.
module tb_multi_cycle_ctrl;

   typedef struct {
      logic [31:0] instr;
      logic        rdy;
      logic        zero;
      logic [3:0]  st;
      logic [11:0] f;
      logic [1:0]  a;
      logic [2:0]  b;
      logic [1:0]  ps;
      logic [8:0]  fl;   // {pc_we, ir_we, mem_req, mem_we, iord, rf_we, reg_dst, mem_to_reg, illegal}
      logic [31:0] ir;
   } vec_t;

   localparam logic [31:0] I_ADD = 32'h012A4020, I_SRA = 32'h00084083, I_LUI = 32'h3C081234,
                           I_LW  = 32'h8D090004, I_SW  = 32'hAD090004, I_BEQ = 32'h11090003,
                           I_BNE = 32'h15090003, I_J   = 32'h08000010, I_ILL1 = 32'hFC000000,
                           I_ILL2 = 32'h0000003F;

   logic        clk, rstn, mem_ready, alu_zero;
   logic [31:0] instr;
   logic [11:0] alu_f;
   logic [1:0]  alu_src_a, pc_src;
   logic [2:0]  alu_src_b;
   logic        pc_we, ir_we, mem_req, mem_we, iord, rf_we, reg_dst, mem_to_reg, illegal;
   logic [3:0]  state;
   logic [31:0] instret;

   logic [11:0] s_alu_f;
   logic [1:0]  s_alu_src_a, s_pc_src;
   logic [2:0]  s_alu_src_b;
   logic        s_pc_we, s_ir_we, s_mem_req, s_mem_we, s_iord, s_rf_we, s_reg_dst, s_mem_to_reg, s_illegal;
   logic [3:0]  s_state;
   logic [2:0]  s_instret;

   int total = 0;
   int bad   = 0;
   vec_t vecs[$];

   multi_cycle_ctrl #(.INSTRET_W(32)) u_dut (
      .clk(clk), .rstn(rstn), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
      .alu_f(alu_f), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .pc_we(pc_we), .ir_we(ir_we), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .rf_we(rf_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
      .state(state), .instret(instret)
   );

   // Narrow counter instance to exercise wrap-around with a handful of retirements.
   multi_cycle_ctrl #(.INSTRET_W(3)) u_small (
      .clk(clk), .rstn(rstn), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
      .alu_f(s_alu_f), .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .pc_src(s_pc_src),
      .pc_we(s_pc_we), .ir_we(s_ir_we), .mem_req(s_mem_req), .mem_we(s_mem_we), .iord(s_iord),
      .rf_we(s_rf_we), .reg_dst(s_reg_dst), .mem_to_reg(s_mem_to_reg), .illegal(s_illegal),
      .state(s_state), .instret(s_instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [31:0] i, input logic r, input logic z,
                               input logic [3:0] s, input logic [11:0] f, input logic [1:0] a,
                               input logic [2:0] b, input logic [1:0] p, input logic [8:0] fl,
                               input logic [31:0] n);
      vec_t v;
      v.instr = i; v.rdy = r; v.zero = z; v.st = s; v.f = f;
      v.a = a; v.b = b; v.ps = p; v.fl = fl; v.ir = n;
      return v;
   endfunction

   function automatic logic [63:0] pack_dut();
      return {state, alu_f, alu_src_a, alu_src_b, pc_src,
              pc_we, ir_we, mem_req, mem_we, iord, rf_we, reg_dst, mem_to_reg, illegal, instret};
   endfunction

   function automatic logic [63:0] pack_exp(input vec_t v);
      return {v.st, v.f, v.a, v.b, v.ps, v.fl, v.ir};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   initial begin
      // add: FETCH, DECODE, EXEC, ALU_WB
      vecs.push_back(mk(I_ADD, 1, 0, 0, 12'h001, 0, 1, 0, 9'h1C0, 0));
      vecs.push_back(mk(I_ADD, 1, 0, 1, 12'h001, 0, 4, 0, 9'h000, 0));
      vecs.push_back(mk(I_ADD, 1, 0, 6, 12'h001, 1, 0, 0, 9'h000, 0));
      vecs.push_back(mk(I_ADD, 1, 0, 7, 12'h001, 0, 0, 0, 9'h00C, 0));
      // sra: shift from rt by shamt
      vecs.push_back(mk(I_SRA, 1, 0, 0, 12'h001, 0, 1, 0, 9'h1C0, 1));
      vecs.push_back(mk(I_SRA, 1, 0, 1, 12'h001, 0, 4, 0, 9'h000, 1));
      vecs.push_back(mk(I_SRA, 1, 0, 6, 12'h400, 2, 5, 0, 9'h000, 1));
      vecs.push_back(mk(I_SRA, 1, 0, 7, 12'h001, 0, 0, 0, 9'h00C, 1));
      // lui: pass-b of imm<<16, writes rt
      vecs.push_back(mk(I_LUI, 1, 0, 0, 12'h001, 0, 1, 0, 9'h1C0, 2));
      vecs.push_back(mk(I_LUI, 1, 0, 1, 12'h001, 0, 4, 0, 9'h000, 2));
      vecs.push_back(mk(I_LUI, 1, 0, 6, 12'h800, 1, 6, 0, 9'h000, 2));
      vecs.push_back(mk(I_LUI, 1, 0, 7, 12'h001, 0, 0, 0, 9'h008, 2));
      // lw with three wait states in MEM_RD
      vecs.push_back(mk(I_LW, 1, 0, 0, 12'h001, 0, 1, 0, 9'h1C0, 3));
      vecs.push_back(mk(I_LW, 1, 0, 1, 12'h001, 0, 4, 0, 9'h000, 3));
      vecs.push_back(mk(I_LW, 1, 0, 2, 12'h001, 1, 2, 0, 9'h000, 3));
      vecs.push_back(mk(I_LW, 0, 0, 3, 12'h001, 0, 0, 0, 9'h050, 3));
      vecs.push_back(mk(I_LW, 0, 0, 3, 12'h001, 0, 0, 0, 9'h050, 3));
      vecs.push_back(mk(I_LW, 0, 0, 3, 12'h001, 0, 0, 0, 9'h050, 3));
      vecs.push_back(mk(I_LW, 1, 0, 3, 12'h001, 0, 0, 0, 9'h050, 3));
      vecs.push_back(mk(I_LW, 1, 0, 4, 12'h001, 0, 0, 0, 9'h00A, 3));
      // sw
      vecs.push_back(mk(I_SW, 1, 0, 0, 12'h001, 0, 1, 0, 9'h1C0, 4));
      vecs.push_back(mk(I_SW, 1, 0, 1, 12'h001, 0, 4, 0, 9'h000, 4));
      vecs.push_back(mk(I_SW, 1, 0, 2, 12'h001, 1, 2, 0, 9'h000, 4));
      vecs.push_back(mk(I_SW, 1, 0, 5, 12'h001, 0, 0, 0, 9'h070, 4));
      // beq taken, bne not taken, both with alu_zero = 1
      vecs.push_back(mk(I_BEQ, 1, 1, 0, 12'h001, 0, 1, 0, 9'h1C0, 5));
      vecs.push_back(mk(I_BEQ, 1, 1, 1, 12'h001, 0, 4, 0, 9'h000, 5));
      vecs.push_back(mk(I_BEQ, 1, 1, 8, 12'h002, 1, 0, 1, 9'h100, 5));
      vecs.push_back(mk(I_BNE, 1, 1, 0, 12'h001, 0, 1, 0, 9'h1C0, 6));
      vecs.push_back(mk(I_BNE, 1, 1, 1, 12'h001, 0, 4, 0, 9'h000, 6));
      vecs.push_back(mk(I_BNE, 1, 1, 8, 12'h002, 1, 0, 1, 9'h000, 6));
      // j
      vecs.push_back(mk(I_J, 1, 0, 0, 12'h001, 0, 1, 0, 9'h1C0, 7));
      vecs.push_back(mk(I_J, 1, 0, 1, 12'h001, 0, 4, 0, 9'h000, 7));
      vecs.push_back(mk(I_J, 1, 0, 9, 12'h001, 0, 0, 2, 9'h100, 7));
      // illegal opcode, then illegal R-type funct: one-cycle pulse, no retire
      vecs.push_back(mk(I_ILL1, 1, 0, 0, 12'h001, 0, 1, 0, 9'h1C0, 8));
      vecs.push_back(mk(I_ILL1, 1, 0, 1, 12'h001, 0, 4, 0, 9'h001, 8));
      vecs.push_back(mk(I_ILL2, 1, 0, 0, 12'h001, 0, 1, 0, 9'h1C0, 8));
      vecs.push_back(mk(I_ILL2, 1, 0, 1, 12'h001, 0, 4, 0, 9'h001, 8));
      // FETCH holds mem_req while memory stalls
      vecs.push_back(mk(I_ADD, 0, 0, 0, 12'h001, 0, 1, 0, 9'h040, 8));
      vecs.push_back(mk(I_ADD, 0, 0, 0, 12'h001, 0, 1, 0, 9'h040, 8));

      rstn      = 1'b0;
      instr     = 32'h0;
      mem_ready = 1'b1;
      alu_zero  = 1'b0;

      // Reset held three cycles: everything quiet even with mem_ready high.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check($sformatf("reset_c%0d", i), pack_dut(),
               {4'd0, 12'h001, 2'd0, 3'd0, 2'd0, 9'h000, 32'd0});
      end

      @(negedge clk);
      rstn      = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      check("first_req", {63'd0, mem_req}, 64'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         instr     = vecs[i].instr;
         mem_ready = vecs[i].rdy;
         alu_zero  = vecs[i].zero;
         #1;
         check($sformatf("vec%0d", i), pack_dut(), pack_exp(vecs[i]));
      end

      // Eight retirements wrap a 3-bit counter back to zero.
      @(negedge clk);
      instr     = I_SW;
      mem_ready = 1'b1;
      alu_zero  = 1'b0;
      #1;
      check("wrap_small", {61'd0, s_instret}, 64'd0);
      check("count_main", {32'd0, instret}, 64'd8);

      // Drive sw into MEM_WR with memory stalled, then reset mid-access.
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      #1;
      check("in_mem_wr", {59'd0, state, mem_we}, {59'd0, 4'd5, 1'b1});
      #2;
      rstn = 1'b0;
      #1;
      check("midop_reset", pack_dut(), {4'd0, 12'h001, 2'd0, 3'd0, 2'd0, 9'h000, 32'd0});

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
